// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory access controller: RV32 func3 codes, FSM states, widths.
// Optional build macro MISALIGN_TRAP_EN is consumed by mem_lane_align.
package mem_pkg;

  localparam int ADDR_W  = 12;
  localparam int WADDR_W = 10;
  localparam int DATA_W  = 32;

  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_RSV3 = 3'd3;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;
  localparam logic [2:0] F3_RSV6 = 3'd6;
  localparam logic [2:0] F3_RSV7 = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic {
    SIDE_IF = 1'b0,
    SIDE_LS = 1'b1
  } side_e;

  function automatic logic is_no_access(input logic [2:0] f3);
    return (f3 == F3_RSV3) || (f3 == F3_RSV6) || (f3 == F3_RSV7);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-side command/data bus between the access controller (master) and the memory (slave).
interface mem_access_ctrl_if;
  import mem_pkg::*;

  logic               mem_read;
  logic               mem_write;
  logic               mem_ifetch;
  logic [WADDR_W-1:0] mem_waddr;
  logic [3:0]         mem_be;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport master (
    output mem_read, mem_write, mem_ifetch, mem_waddr, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_ifetch, mem_waddr, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte-lane logic: store shift and byte enables, load extract and extend.
// With MISALIGN_TRAP_EN defined, misaligned halfword/word accesses are flagged instead of aligned down.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]        func3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              no_access,
  output logic              misaligned
);

  logic [1:0]        eff_lo;
  logic [DATA_W-1:0] rshift;

  always_comb begin
    no_access = is_no_access(func3);
`ifdef MISALIGN_TRAP_EN
    misaligned = ~no_access &
                 (((func3[1:0] == 2'd1) & addr_lo[0]) |
                  ((func3[1:0] == 2'd2) & (addr_lo != 2'b00)));
    eff_lo     = addr_lo;
`else
    misaligned = 1'b0;
    case (func3[1:0])
      2'd1:    eff_lo = {addr_lo[1], 1'b0};
      2'd2:    eff_lo = 2'b00;
      default: eff_lo = addr_lo;
    endcase
`endif
  end

  always_comb begin
    case (func3[1:0])
      2'd0: begin
        be         = 4'b0001 << eff_lo;
        wdata_lane = DATA_W'(wdata[7:0]) << {eff_lo, 3'b000};
      end
      2'd1: begin
        be         = 4'b0011 << {eff_lo[1], 1'b0};
        wdata_lane = DATA_W'(wdata[15:0]) << {eff_lo[1], 4'b0000};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  always_comb begin
    rshift = rdata >> {eff_lo, 3'b000};
    case (func3)
      F3_B:    rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
      F3_BU:   rdata_ext = {24'd0, rshift[7:0]};
      F3_H:    rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
      F3_HU:   rdata_ext = {16'd0, rshift[15:0]};
      F3_W:    rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates one fetch port and one load/store port onto a single-word memory (IDLE/ISSUE/RESP).
// Optional MISALIGN_TRAP_EN build turns misaligned load/store into a faulting, command-less response.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_func3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_fault,
  output logic              stall,
  mem_access_ctrl_if.master mem
);

  logic [1:0]         state_q, state_d;
  side_e              side_q, side_d;
  logic [2:0]         func3_q, func3_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic               we_q, we_d;
  logic               if_ready_q, if_ready_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic               ls_ready_q, ls_ready_d;
  logic [DATA_W-1:0]  ls_rdata_q, ls_rdata_d;
  logic               ls_fault_q, ls_fault_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_ifetch_q, mem_ifetch_d;
  logic [WADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [2:0]         la_func3;
  logic [1:0]         la_addr_lo;
  logic [3:0]         la_be;
  logic [DATA_W-1:0]  la_wdata;
  logic [DATA_W-1:0]  la_rdata;
  logic               la_no_access;
  logic               la_misaligned;
  logic               unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  // In IDLE the lane logic sees the live request; afterwards it sees the captured one.
  assign la_func3   = (state_q == ST_IDLE) ? ls_func3     : func3_q;
  assign la_addr_lo = (state_q == ST_IDLE) ? ls_addr[1:0] : addr_lo_q;

  mem_lane_align u_lane_align (
    .func3      (la_func3),
    .addr_lo    (la_addr_lo),
    .wdata      (ls_wdata),
    .rdata      (mem.mem_rdata),
    .be         (la_be),
    .wdata_lane (la_wdata),
    .rdata_ext  (la_rdata),
    .no_access  (la_no_access),
    .misaligned (la_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    func3_d      = func3_q;
    addr_lo_d    = addr_lo_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_ready_d   = 1'b0;
    ls_ready_d   = 1'b0;
    ls_fault_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_ifetch_d = 1'b0;
    mem_waddr_d  = '0;
    mem_be_d     = '0;
    mem_wdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (ls_req) begin
          state_d   = ST_ISSUE;
          side_d    = SIDE_LS;
          func3_d   = ls_func3;
          addr_lo_d = ls_addr[1:0];
          we_d      = ls_we;
          if (!la_no_access && !la_misaligned) begin
            mem_read_d  = ~ls_we;
            mem_write_d = ls_we;
            mem_waddr_d = ls_addr[ADDR_W-1:2];
            mem_be_d    = la_be;
            mem_wdata_d = ls_we ? la_wdata : '0;
          end
        end else if (if_req) begin
          state_d      = ST_ISSUE;
          side_d       = SIDE_IF;
          mem_read_d   = 1'b1;
          mem_ifetch_d = 1'b1;
          mem_waddr_d  = if_addr[ADDR_W-1:2];
          mem_be_d     = 4'b1111;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        if (side_q == SIDE_LS) begin
          ls_ready_d = 1'b1;
          ls_fault_d = la_misaligned;
          ls_rdata_d = (we_q || la_no_access || la_misaligned) ? '0 : la_rdata;
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = mem.mem_rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      side_q       <= SIDE_IF;
      func3_q      <= '0;
      addr_lo_q    <= '0;
      we_q         <= 1'b0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      ls_ready_q   <= 1'b0;
      ls_rdata_q   <= '0;
      ls_fault_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_ifetch_q <= 1'b0;
      mem_waddr_q  <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      func3_q      <= func3_d;
      addr_lo_q    <= addr_lo_d;
      we_q         <= we_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      ls_ready_q   <= ls_ready_d;
      ls_rdata_q   <= ls_rdata_d;
      ls_fault_q   <= ls_fault_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_ifetch_q <= mem_ifetch_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_ready       = if_ready_q;
  assign if_rdata       = if_rdata_q;
  assign ls_ready       = ls_ready_q;
  assign ls_rdata       = ls_rdata_q;
  assign ls_fault       = ls_fault_q;
  assign mem.mem_read   = mem_read_q;
  assign mem.mem_write  = mem_write_q;
  assign mem.mem_ifetch = mem_ifetch_q;
  assign mem.mem_waddr  = mem_waddr_q;
  assign mem.mem_be     = mem_be_q;
  assign mem.mem_wdata  = mem_wdata_q;

  // Gated by rst_n so stall also drops the instant reset asserts.
  assign stall = rst_n &
                 ((if_req & ~((state_q == ST_RESP) & (side_q == SIDE_IF))) |
                  (ls_req & ~((state_q == ST_RESP) & (side_q == SIDE_LS))));

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-002 SHALL have fetch-side ports: if_req in 1 fetch request (level, held until if_ready); if_addr in 12 byte address; if_ready out 1 one-cycle response pulse; if_rdata out 32 fetched word.
REQ-003 SHALL have load/store-side ports: ls_req in 1 request (level, held until ls_ready); ls_we in 1 1=store; ls_func3 in 3 RV32 width/sign code; ls_addr in 12 byte address; ls_wdata in 32 store data (LSB-justified); ls_ready out 1 one-cycle response pulse; ls_rdata out 32 extended load data; ls_fault out 1 misaligned-access flag, valid with ls_ready.
REQ-004 SHALL have memory-side ports: mem_read out 1; mem_write out 1; mem_ifetch out 1 1=instruction region, 0=data region; mem_waddr out 10 word address; mem_be out 4 byte enables; mem_wdata out 32 lane-aligned write data; mem_rdata in 32 raw word, valid the cycle after the command edge.
REQ-005 SHALL have stall out 1 = pending request not yet answered.

Function
REQ-006 SHALL implement states IDLE, ISSUE, RESP; IDLE->ISSUE on accepted request, ISSUE->RESP always, RESP->IDLE always.
REQ-007 SHALL accept only in IDLE; when both requests present, ls_req SHALL win; fetch waits.
REQ-008 SHALL register mem_* outputs on acceptance and hold them for the ISSUE cycle only; all mem_* SHALL be 0 in IDLE and RESP.
REQ-009 SHALL capture mem_rdata at the ISSUE->RESP edge and pulse the matching ready in RESP: latency exactly 2 cycles from accept edge to ready.
REQ-010 SHALL hold if_rdata / ls_rdata stable from RESP until the next response of the same side.
REQ-011 SHALL derive mem_waddr = addr[11:2]; mem_be: SB 0001<<addr[1:0], SH 0011<<(2*addr[1]), SW 1111.
REQ-012 SHALL lane-shift store data: byte replicated to addressed lane, halfword to addressed half.
REQ-013 SHALL extract loads by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-014 SHALL treat func3 3,6,7 as no-access: no mem command, ls_ready in RESP, ls_rdata=0.
REQ-015 SHALL drive mem_ifetch=1 only for fetch commands; fetch SHALL always be a 4-byte read with mem_be=1111.
REQ-016 SHALL assert stall = (if_req|ls_req) & ~(state==RESP for that side).
REQ-017 SHALL never assert mem_read and mem_write together.

Reset
REQ-018 SHALL on rst_n low force IDLE and all outputs (readies, data, fault, mem_*, stall) to 0, immediately and regardless of state.
REQ-019 SHALL abandon an in-flight access on reset; no response pulse SHALL follow release.
REQ-020 SHALL resume acceptance on the first rising edge with rst_n high.

Configuration
REQ-021 SHALL, with MISALIGN_TRAP_EN defined, detect SH/LH/LHU with addr[0]=1 and SW/LW with addr[1:0]!=0, issue no mem command, and pulse ls_ready with ls_fault=1 in RESP.
REQ-022 SHALL, without MISALIGN_TRAP_EN, tie ls_fault to 0 and force addr low bits to width alignment.

Structure
REQ-023 SHALL place func3 codes, state enumeration and address-width constants in shared package mem_pkg.
REQ-024 SHALL contain one sub-module mem_lane_align (store shift/byte-enable and load extract/extend, combinational).

Verification
REQ-025 Fetch if_addr=0x010, mem_rdata=0x00500093 -> mem_read=1, mem_ifetch=1, mem_waddr=4 in ISSUE; if_ready with 0x00500093 two cycles after accept.
REQ-026 SB ls_addr=0x083, ls_wdata=0xAB -> mem_write=1, mem_be=1000, mem_wdata=0xAB000000, mem_waddr=0x20.
REQ-027 LB ls_addr=0x081, mem_rdata=0x0000F000 -> ls_rdata=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-028 if_req and ls_req asserted in same cycle -> load/store served first, fetch accepted in next IDLE, stall high throughout.
REQ-029 MISALIGN_TRAP_EN defined, LW ls_addr=0x082 -> no mem_read, ls_ready with ls_fault=1; undefined -> mem_waddr=0x20, ls_fault=0.
REQ-030 rst_n low during ISSUE of store -> mem_write drops to 0 at once, no ls_ready after release, next request served normally.
